// File: rtl/isqrt_seq_if.sv
// Handshake/result bundle between the sqrt operand/result registers and isqrt_seq.
// The master drives start/radicand; the slave returns busy/done/root/remainder.
interface isqrt_seq_if #(
    parameter int WIDTH = 32
);
    localparam int RW  = WIDTH / 2;
    localparam int RMW = RW + 1;

    logic             start;
    logic [WIDTH-1:0] radicand;
    logic             busy;
    logic             done;
    logic [RW-1:0]    root;
    logic [RMW-1:0]   remainder;

    modport master (
        output start, radicand,
        input  busy, done, root, remainder
    );

    modport slave (
        input  start, radicand,
        output busy, done, root, remainder
    );
endinterface

// File: rtl/isqrt_seq.sv
// Sequential restoring integer square root, one root bit per clock.
// Optional ISQRT_ROUND_EN rounds the root output to nearest (saturating).
//
// state | meaning
// IDLE  | waiting for start; outputs hold last result
// RUN   | one restoring iteration per edge, RW iterations total
// DONE  | one-cycle done pulse, results valid
module isqrt_seq #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    isqrt_seq_if.slave  bus
);
    localparam int RW  = WIDTH / 2;
    localparam int RMW = RW + 1;
    localparam int IW  = RW + 2;
    localparam int CW  = (RW > 1) ? $clog2(RW) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_sh;
    logic [RW-1:0]    r_root;
    logic [IW-1:0]    r_rem;
    logic [CW-1:0]    r_cnt;
    logic [RW-1:0]    r_root_out;
    logic [RMW-1:0]   r_rem_out;

    logic [IW+1:0]    w_part;
    logic [IW+1:0]    w_trial;
    logic             w_ge;
    logic [IW-1:0]    w_rem_next;
    logic [RW-1:0]    w_root_next;
    logic [RW-1:0]    w_root_res;
    logic             w_last;

    assign w_part      = {r_rem, r_sh[WIDTH-1 -: 2]};
    assign w_trial     = {2'b00, r_root, 2'b01};
    assign w_ge        = (w_part >= w_trial);
    assign w_rem_next  = w_ge ? IW'(w_part - w_trial) : IW'(w_part);
    assign w_root_next = RW'({r_root, w_ge});
    assign w_last      = (r_cnt == CW'(RW - 1));

`ifdef ISQRT_ROUND_EN
    // Remainder above the root means the true root is past the halfway point.
    assign w_root_res = ((w_rem_next > IW'(w_root_next)) && !(&w_root_next))
                        ? w_root_next + 1'b1 : w_root_next;
`else
    assign w_root_res = w_root_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_RUN;
            S_RUN:   if (w_last)    w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh       <= '0;
            r_root     <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_root_out <= '0;
            r_rem_out  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sh   <= bus.radicand;
                        r_root <= '0;
                        r_rem  <= '0;
                        r_cnt  <= '0;
                    end
                end
                S_RUN: begin
                    r_sh   <= {r_sh[WIDTH-3:0], 2'b00};
                    r_root <= w_root_next;
                    r_rem  <= w_rem_next;
                    r_cnt  <= r_cnt + 1'b1;
                    // Final remainder never exceeds 2*root, so RMW bits are enough.
                    if (w_last) begin
                        r_root_out <= w_root_res;
                        r_rem_out  <= RMW'(w_rem_next);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.root      = r_root_out;
    assign bus.remainder = r_rem_out;
endmodule

// File: tb/tb_isqrt_seq.sv
// Self-checking bench for isqrt_seq (WIDTH=32) against an arithmetic sqrt model.
// Honours ISQRT_ROUND_EN when the same macro is defined for the bench.
module tb_isqrt_seq;
    localparam int W  = 32;
    localparam int RW = W / 2;

`ifdef ISQRT_ROUND_EN
    localparam logic [15:0] EXP_R21 = 16'd5;
`else
    localparam logic [15:0] EXP_R21 = 16'd4;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cmp_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    isqrt_seq_if #(.WIDTH(W)) bus();

    isqrt_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] fsqrt(input logic [31:0] x);
        longint lo, hi, mid, xv;
        logic [15:0] r;
        lo = 0;
        hi = 65535;
        xv = longint'(x);
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= xv) lo = mid;
            else hi = mid - 1;
        end
        r = lo[15:0];
        return r;
    endfunction

    function automatic logic [16:0] frem(input logic [31:0] x);
        longint r, d;
        logic [16:0] v;
        r = longint'(fsqrt(x));
        d = longint'(x) - r * r;
        v = d[16:0];
        return v;
    endfunction

    function automatic logic [15:0] froot_out(input logic [31:0] x);
        logic [15:0] r;
        r = fsqrt(x);
`ifdef ISQRT_ROUND_EN
        if (longint'(frem(x)) > longint'(r) && r != 16'hFFFF) r = r + 16'd1;
`endif
        return r;
    endfunction

    // Timeline model: an accepted start makes the unit busy for RW+1 cycles,
    // the last of which carries done and fresh results.
    int          m_left = 0;
    logic [31:0] m_op = '0;
    logic [15:0] exp_root = '0;
    logic [16:0] exp_rem = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left   = 0;
            exp_root = '0;
            exp_rem  = '0;
        end else if (m_left == 0) begin
            if (bus.start === 1'b1) begin
                m_left = RW + 1;
                m_op   = bus.radicand;
            end
        end else begin
            if (m_left == 2) begin
                exp_root = froot_out(m_op);
                exp_rem  = frem(m_op);
            end
            m_left--;
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("cyc_busy", 64'(bus.busy), 64'(m_left != 0));
            chk("cyc_done", 64'(bus.done), 64'(m_left == 1));
            chk("cyc_root", 64'(bus.root), 64'(exp_root));
            chk("cyc_rem",  64'(bus.remainder), 64'(exp_rem));
        end
    end

    task automatic op(input logic [31:0] x, input string nm);
        int n;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.radicand = x;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            bus.start    = 1'b0;
            bus.radicand = $urandom;
        end while (bus.done !== 1'b1 && n < 100);
        chk({nm, "_latency"}, 64'(n), 64'(RW + 1));
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] s;
        case ($urandom_range(0, 5))
            0: pick = 32'd0;
            1: pick = 32'hFFFF_FFFF;
            2: begin s = $urandom_range(0, 65535); pick = s * s; end
            3: begin s = $urandom_range(1, 65535); pick = s * s - 32'd1; end
            4: pick = $urandom_range(0, 1023);
            default: pick = $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int dn [$];
        bus.start    = 1'b0;
        bus.radicand = '0;

        chk("model_sqrt_144",  64'(fsqrt(32'd144)), 64'd12);
        chk("model_rem_17",    64'(frem(32'd17)), 64'd1);
        chk("model_sqrt_max",  64'(fsqrt(32'hFFFF_FFFF)), 64'hFFFF);
        chk("model_rem_max",   64'(frem(32'hFFFF_FFFF)), 64'h1FFFE);
        chk("model_sqrt_1e6",  64'(fsqrt(32'd1000000)), 64'd1000);
        chk("model_root_21",   64'(froot_out(32'd21)), 64'(EXP_R21));

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_root", 64'(bus.root), 64'd0);
        chk("rst_rem",  64'(bus.remainder), 64'd0);
        rst    = 1'b0;
        cmp_en = 1'b1;

        op(32'd0, "zero");
        chk("zero_root", 64'(bus.root), 64'd0);
        chk("zero_rem",  64'(bus.remainder), 64'd0);
        @(negedge clk);
        chk("zero_busy_after", 64'(bus.busy), 64'd0);

        op(32'd144, "r144");
        chk("r144_root", 64'(bus.root), 64'd12);
        chk("r144_rem",  64'(bus.remainder), 64'd0);
        op(32'd17, "r17");
        chk("r17_root", 64'(bus.root), 64'd4);
        chk("r17_rem",  64'(bus.remainder), 64'd1);
        op(32'hFFFF_FFFF, "rmax");
        chk("rmax_root", 64'(bus.root), 64'hFFFF);
        chk("rmax_rem",  64'(bus.remainder), 64'h1FFFE);

        // Starts during RUN and during DONE must be ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.radicand = 32'd144;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.start = 1'b1; bus.radicand = 32'd17;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("ign_done_seen", 64'(bus.done), 64'd1);
        bus.start = 1'b1; bus.radicand = 32'd17;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ign_busy", 64'(bus.busy), 64'd0);
        repeat (3) @(negedge clk);
        chk("ign_root", 64'(bus.root), 64'd12);
        chk("ign_rem",  64'(bus.remainder), 64'd0);

        // Abort mid-RUN with reset.
        bus.start = 1'b1; bus.radicand = 32'd1000000;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_root", 64'(bus.root), 64'd0);
        chk("abort_rem",  64'(bus.remainder), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        op(32'd1000000, "r1e6");
        chk("r1e6_root", 64'(bus.root), 64'd1000);
        chk("r1e6_rem",  64'(bus.remainder), 64'd0);

        // Start held high: a new operation every RW+2 cycles.
        @(negedge clk);
        bus.start = 1'b1; bus.radicand = 32'd50;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dn.push_back(i);
        end
        bus.start = 1'b0;
        chk("b2b_count", 64'(dn.size()), 64'd3);
        if (dn.size() == 3) begin
            chk("b2b_first", 64'(dn[0]), 64'(RW + 1));
            chk("b2b_gap1",  64'(dn[1] - dn[0]), 64'(RW + 2));
            chk("b2b_gap2",  64'(dn[2] - dn[1]), 64'(RW + 2));
        end
        chk("b2b_root", 64'(bus.root), 64'd7);
        chk("b2b_rem",  64'(bus.remainder), 64'd1);
        repeat (RW + 4) @(negedge clk);

        op(32'd20, "r20");
        chk("r20_root", 64'(bus.root), 64'd4);
        chk("r20_rem",  64'(bus.remainder), 64'd4);
        op(32'd21, "r21");
        chk("r21_root", 64'(bus.root), 64'(EXP_R21));
        chk("r21_rem",  64'(bus.remainder), 64'd5);
        op(32'hFFFF_FFFF, "rmax2");
        chk("rmax2_root", 64'(bus.root), 64'hFFFF);

        // Random traffic, including start noise while busy.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.start    = ($urandom_range(0, 3) == 0);
            bus.radicand = pick();
        end
        bus.start = 1'b0;
        repeat (RW + 4) @(negedge clk);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
